// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared FSM state type for the RX deserializer
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_bit_counter.sv
// rtl/rx_bit_counter.sv - frame bit counter, cleared by start, advanced by shift
// term flags the shift that brings the count to DATA_W.
module rx_bit_counter #(
  parameter int DATA_W = 8,
  localparam int CW = $clog2(DATA_W + 1)
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic shift,
  input  logic en,
  output logic term
);

  logic [CW-1:0] cnt;

  // A start coinciding with a shift already counts that bit as bit 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= shift ? CW'(1) : '0;
    end else if (en && shift) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign term = en && shift && !start && (cnt == CW'(DATA_W - 1));

endmodule

// File: rtl/rx_deserializer.sv
// rtl/rx_deserializer.sv - framed serial-to-parallel receiver with valid/ready output
// Optional even-parity check is built when RX_PARITY_EN is defined.
module rx_deserializer
  import rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              shift,
  input  logic              tx_data,
  output logic [DATA_W-1:0] shr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              overrun,
  output logic              parity_err
);

  rx_state_t         state;
  logic              term;
  logic              take;
  logic              frame_done;
  logic              load;
  logic              xfer;
  logic [DATA_W-1:0] shr_next;
  logic [DATA_W-1:0] word;

  rx_bit_counter #(.DATA_W(DATA_W)) u_cnt (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .shift (shift),
    .en    (state == SHIFT),
    .term  (term)
  );

  always_comb begin
    shr_next = MSB_FIRST ? {shr[DATA_W-2:0], tx_data} : {tx_data, shr[DATA_W-1:1]};
  end

  assign take = shift && (start || state == SHIFT);
  assign xfer = data_valid && data_ready;
  assign load = !data_valid || data_ready;

`ifdef RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
  assign frame_done = (state == PARITY) && shift && !start;
  assign word       = shr;

  always_ff @(posedge clk) begin
    if (clr) begin
      parity_err <= 1'b0;
    end else if (frame_done && load) begin
      parity_err <= (^shr) ^ tx_data;
    end
  end
`else
  localparam rx_state_t AFTER_DATA = IDLE;
  assign frame_done = term;
  assign word       = shr_next;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      shr        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (take) shr <= shr_next;

      if (start) begin
        state <= SHIFT;
      end else begin
        case (state)
          IDLE:    state <= IDLE;
          SHIFT:   if (term) state <= AFTER_DATA;
`ifdef RX_PARITY_EN
          PARITY:  if (shift) state <= IDLE;
`endif
          default: state <= IDLE;
        endcase
      end

      // A commit on the same edge as a transfer reloads rather than drops.
      if (frame_done) begin
        if (load) begin
          data_out   <= word;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_deserializer.sv
// tb/tb_rx_deserializer.sv - bench for rx_deserializer, LSB- and MSB-first instances
// Follows RX_PARITY_EN to decide whether frames carry a parity bit.
module tb_rx_deserializer;

`ifdef RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b0, start = 1'b0, shift = 1'b0, tx_data = 1'b0, data_ready = 1'b0;
  logic [7:0] shr_l, shr_m, dout_l, dout_m;
  logic valid_l, valid_m, over_l, over_m, perr_l, perr_m;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rx_deserializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr(clr), .start(start), .shift(shift), .tx_data(tx_data),
    .shr(shr_l), .data_out(dout_l), .data_valid(valid_l), .data_ready(data_ready),
    .overrun(over_l), .parity_err(perr_l)
  );

  rx_deserializer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clr(clr), .start(start), .shift(shift), .tx_data(tx_data),
    .shr(shr_m), .data_out(dout_m), .data_valid(valid_m), .data_ready(data_ready),
    .overrun(over_m), .parity_err(perr_m)
  );

  // Model: history of sampled data bits plus frame progress.
  bit         hist[$];
  bit         in_frame, par_phase;
  int         nbits;
  logic [7:0] m_dl, m_dm;
  bit         m_valid, m_over, m_perr;

  function automatic logic [7:0] hist_word(input bit msb);
    logic [7:0] w;
    int n;
    int idx;
    w = '0;
    n = hist.size();
    for (int i = 0; i < 8; i++) begin
      idx = msb ? n - 1 - i : n - 8 + i;
      if (idx >= 0) w[i] = hist[idx];
    end
    return w;
  endfunction

  task automatic model(input bit st, input bit sh, input bit d, input bit rdy, input bit c);
    bit xfer, done, p;
    if (c) begin
      hist.delete();
      in_frame = 0; par_phase = 0; nbits = 0;
      m_dl = '0; m_dm = '0; m_valid = 0; m_over = 0; m_perr = 0;
    end else begin
      xfer = m_valid && rdy;
      done = 0;
      p = 0;
      if (st) begin
        in_frame = 1; nbits = 0; par_phase = 0;
      end
      if (sh && in_frame) begin
        if (par_phase) begin
          p = (^hist_word(1'b0)) ^ d;
          done = 1;
        end else begin
          hist.push_back(d);
          if (hist.size() > 8) void'(hist.pop_front());
          nbits++;
          if (nbits == 8) begin
            if (PAR) par_phase = 1;
            else done = 1;
          end
        end
      end
      if (done) begin
        in_frame = 0;
        par_phase = 0;
        if (!m_valid || xfer) begin
          m_dl = hist_word(1'b0);
          m_dm = hist_word(1'b1);
          m_valid = 1;
          m_perr = p;
        end else begin
          m_over = 1;
        end
      end else if (xfer) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic compare();
    chk("shr_lsb",   shr_l,   hist_word(1'b0));
    chk("shr_msb",   shr_m,   hist_word(1'b1));
    chk("dout_lsb",  dout_l,  m_dl);
    chk("dout_msb",  dout_m,  m_dm);
    chk("valid_lsb", valid_l, m_valid);
    chk("valid_msb", valid_m, m_valid);
    chk("over_lsb",  over_l,  m_over);
    chk("over_msb",  over_m,  m_over);
    chk("perr_lsb",  perr_l,  m_perr);
    chk("perr_msb",  perr_m,  m_perr);
  endtask

  task automatic step(input bit st, input bit sh, input bit d, input bit rdy, input bit c);
    start = st; shift = sh; tx_data = d; data_ready = rdy; clr = c;
    model(st, sh, d, rdy, c);
    @(posedge clk);
    #1;
    compare();
  endtask

  // Sends w bit 0 first; rdy is applied only on the final-bit cycle.
  task automatic frame(input logic [7:0] w, input bit par, input bit merged,
                       input bit rdy, input bit gap);
    logic [7:0] v;
    v = w;
    if (!merged) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(merged && i == 0, 1, v[i], (!PAR && i == 7) ? rdy : 1'b0, 0);
      if (gap && i == 3) step(0, 0, 0, 0, 0);
    end
    if (PAR) step(0, 1, par, rdy, 0);
  endtask

  initial begin
    model(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_shr", shr_l, 32'h0);
    chk("reset_valid", valid_l, 32'h0);

    step(0, 1, 1, 0, 0);
    frame(8'h1E, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lsb_1e", dout_l, 32'h1E);
    chk("msb_78", dout_m, 32'h78);
    chk("valid_1e", valid_l, 32'h1);
    chk("perr_1e_even", perr_l, 32'h0);

    frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("keep_1e", dout_l, 32'h1E);
    chk("overrun_set", over_l, 32'h1);
    step(0, 0, 0, 1, 0);
    chk("valid_fall", valid_l, 32'h0);
    chk("overrun_sticky", over_l, 32'h1);
    step(0, 0, 0, 0, 0);

    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("abort_5a", dout_l, 32'h5A);
    chk("abort_5a_msb", dout_m, 32'h5A);
    chk("abort_no_over", over_l, 32'h0);
    step(0, 0, 0, 1, 0);

    frame(8'h1E, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("perr_bad_parity", perr_l, {31'h0, PAR});
    step(0, 0, 0, 1, 0);

    frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reload_c3", dout_l, 32'hC3);
    chk("reload_valid", valid_l, 32'h1);
    chk("reload_no_over", over_l, 32'h0);
    step(0, 0, 0, 1, 0);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, i[0], 0, 0);
    step(1, 1, 1, 0, 1);
    chk("clr_shr", shr_l, 32'h0);
    chk("clr_dout", dout_l, 32'h0);
    chk("clr_valid", valid_l, 32'h0);
    chk("clr_over", over_l, 32'h0);
    frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_clr_3c", dout_l, 32'h3C);
    chk("after_clr_valid", valid_l, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rx_deserializer.md
# rx_deserializer

Parametrised serial-to-parallel receiver; the next generation of the RX shift register. Collects a framed serial bit stream of `DATA_W` bits (LSB- or MSB-first) into a holding register, presents completed words with a valid/ready handshake, and flags overrun. Sits between the RX bit-timing logic, which supplies `start`/`shift` strobes, and the RX consumer.

## Interface
- `DATA_W`, 8: word width in bits, 2..32.
- `MSB_FIRST`, 0: 0 means the first received bit lands in bit 0 (right shift, insert at MSB); 1 means the first received bit lands in bit `DATA_W-1` (left shift, insert at LSB).
- `clk`  in  1  clock; all logic on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `start`  in  1  frame start strobe, one cycle.
- `shift`  in  1  bit strobe: sample `tx_data` this cycle.
- `tx_data`  in  1  serial data bit.
- `shr`  out  `DATA_W`  live shift register contents.
- `data_out`  out  `DATA_W`  holding register, the completed word.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `data_ready`  in  1  consumer accepts the word.
- `overrun`  out  1  sticky: a completed word was dropped.
- `parity_err`  out  1  parity result for `data_out`; 0 when parity is compiled out.

## Operation
- States are IDLE, SHIFT and PARITY. PARITY exists only with `RX_PARITY_EN`.
- Bit counter `cnt`, width `$clog2(DATA_W+1)`.
- IDLE:
  - `shift` without `start` is ignored.
  - `start` moves the FSM to SHIFT with `cnt`=0.
- SHIFT: each `shift` pulse shifts `tx_data` into `shr` per `MSB_FIRST` and increments `cnt`.
- When the `DATA_W`-th bit is sampled:
  - Without parity: commit the word and return to IDLE.
  - With parity: go to PARITY.
- PARITY:
  - The next `shift` samples the parity bit.
  - `parity_err` = XOR of the data bits XOR the parity bit (even parity).
  - Then commit the word and return to IDLE.
- Commit:
  - If `data_valid`=0, or the word is being consumed on the same edge (`data_valid & data_ready`): load `data_out` and `parity_err`, and set `data_valid`=1.
  - Otherwise: drop the new word, keep the old `data_out`, and set `overrun`=1.
- Handshake:
  - A transfer happens on an edge with `data_valid & data_ready`.
  - `data_valid` falls on that edge unless a commit on the same edge reloads it.
  - `data_ready` while `data_valid`=0 has no effect.
- `start` in SHIFT or PARITY aborts the current frame:
  - `cnt` restarts at 0 and the FSM goes to SHIFT.
  - `shr` is not cleared.
  - The partial word is discarded; no overrun.
- `start` and `shift` in the same cycle: the bit is sampled as bit 0 of the new frame (`cnt`=1).
- `shr` is never cleared by frame start. It is cleared only by `clr`.
- `overrun` is cleared only by `clr`.

## Timing
- Reset values: `shr`=0, `data_out`=0, `data_valid`=0, `overrun`=0, `parity_err`=0, FSM=IDLE, `cnt`=0.
- `clr` overrides all other inputs, mid-frame included.
- `shr` updates on the edge that samples `shift`.
- `data_out` and `data_valid` update on the same edge that samples the final bit: the data bit without parity, the parity bit with it. Zero cycles of added latency.
- Back-to-back frames: `start` is accepted on the cycle after the final-bit edge.
- Minimum frame is `DATA_W` cycles without parity and `DATA_W+1` cycles with it.

## Configuration
- `RX_PARITY_EN` defined:
  - The PARITY state and the parity check are built.
  - A frame is `DATA_W+1` shifts.
  - `parity_err` is valid with each committed word.
- `RX_PARITY_EN` undefined:
  - There is no PARITY state.
  - A frame is `DATA_W` shifts.
  - `parity_err` is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package `rx_pkg`: the `rx_state_t` enum (IDLE, SHIFT, PARITY) and its encoding.
- One natural sub-module, `rx_bit_counter`:
  - A parametrised counter with clear-on-start and increment-on-shift.
  - Outputs a terminal flag at `DATA_W`.
- The FSM, shift register and holding register live in `rx_deserializer`.

## Test plan
- `DATA_W`=8, `MSB_FIRST`=0, start, then bits 0,1,1,1,1,0,0,0 -> `data_out`=0x1E and `data_valid`=1 on the 8th shift edge.
- Same bit stream with `MSB_FIRST`=1 -> `data_out`=0x78.
- Two frames, 0x1E then 0xA5, with `data_ready`=0 throughout -> `data_out` stays 0x1E and `overrun`=1. Raise `data_ready` -> `data_valid` falls; `overrun` stays 1 until `clr`.
- Partial frame of 0xFF (4 bits), then `start` with `shift` in the same cycle, then a full 0x5A -> `data_out`=0x5A and `overrun`=0.
- `RX_PARITY_EN`: 0x1E with parity bit 0 -> `parity_err`=0. With parity bit 1 -> `parity_err`=1.
- `clr` asserted after 5 bits -> all outputs 0 and FSM in IDLE. A following full frame 0x3C is received correctly.
